// File: rtl/wavelink_bus_pkg.sv
// Shared Avalon-MM definitions for the wavelink fabric: arbiter states, error word, default widths.
package wavelink_bus_pkg;

   typedef enum logic [1:0] {
      StIdle,
      StGrant,
      StRdwait
   } arb_state_e;

   localparam logic [31:0] AVMM_ERR_DATA = 32'hDEADBEEF;
   localparam int unsigned AVMM_AW       = 16;
   localparam int unsigned AVMM_DW       = 32;

endpackage

// File: rtl/wavelink_avmm_arbiter.sv
// Two-master, one-slave Avalon-MM arbiter: round-robin grant, one transaction in flight,
// reads bounded by a timeout that returns ERR_DATA so a dead slave cannot hang a master.
module wavelink_avmm_arbiter
   import wavelink_bus_pkg::*;
#(
   parameter int unsigned AW          = AVMM_AW,
   parameter int unsigned DW          = AVMM_DW,
   parameter int unsigned TIMEOUT_CYC = 256,
   parameter logic [31:0] ERR_DATA    = AVMM_ERR_DATA
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [AW-1:0]   m0_address,
   input  logic            m0_read,
   input  logic            m0_write,
   input  logic [DW-1:0]   m0_writedata,
   input  logic [DW/8-1:0] m0_byteenable,
   output logic            m0_waitrequest,
   output logic [DW-1:0]   m0_readdata,
   output logic            m0_readdatavalid,
   input  logic [AW-1:0]   m1_address,
   input  logic            m1_read,
   input  logic            m1_write,
   input  logic [DW-1:0]   m1_writedata,
   input  logic [DW/8-1:0] m1_byteenable,
   output logic            m1_waitrequest,
   output logic [DW-1:0]   m1_readdata,
   output logic            m1_readdatavalid,
   output logic [AW-1:0]   s_address,
   output logic            s_read,
   output logic            s_write,
   output logic [DW-1:0]   s_writedata,
   output logic [DW/8-1:0] s_byteenable,
   input  logic            s_waitrequest,
   input  logic [DW-1:0]   s_readdata,
   input  logic            s_readdatavalid,
   output logic            owner,
   output logic            timeout_pulse
);

   localparam int unsigned   CW       = $clog2(TIMEOUT_CYC);
   localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT_CYC - 1);
   localparam logic [DW-1:0] ERR_WORD = DW'(ERR_DATA);

   arb_state_e          state_q, state_d;
   logic                owner_q, owner_d;
   logic                rr_next_q, rr_next_d;
   logic [CW-1:0]       cnt_q, cnt_d;

   logic                req0, req1;
   logic                sel_rd, sel_wr;
   logic [AW-1:0]       sel_addr;
   logic [DW-1:0]       sel_wdata;
   logic [DW/8-1:0]     sel_be;
   logic                rd_valid;
   logic [DW-1:0]       rd_data;

   assign req0      = m0_read | m0_write;
   assign req1      = m1_read | m1_write;
   // read & write together from one master is treated as a write
   assign sel_wr    = owner_q ? m1_write : m0_write;
   assign sel_rd    = (owner_q ? m1_read : m0_read) & ~sel_wr;
   assign sel_addr  = owner_q ? m1_address : m0_address;
   assign sel_wdata = owner_q ? m1_writedata : m0_writedata;
   assign sel_be    = owner_q ? m1_byteenable : m0_byteenable;
   assign owner     = owner_q;

   always_comb begin
      state_d        = state_q;
      owner_d        = owner_q;
      rr_next_d      = rr_next_q;
      cnt_d          = cnt_q;
      s_address      = '0;
      s_read         = 1'b0;
      s_write        = 1'b0;
      s_writedata    = '0;
      s_byteenable   = '0;
      m0_waitrequest = 1'b1;
      m1_waitrequest = 1'b1;
      rd_valid       = 1'b0;
      rd_data        = '0;
      timeout_pulse  = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (req0 || req1) begin
               owner_d = (req0 && req1) ? rr_next_q : req1;
               state_d = StGrant;
            end
         end
         StGrant: begin
            s_address    = sel_addr;
            s_read       = sel_rd;
            s_write      = sel_wr;
            s_writedata  = sel_wdata;
            s_byteenable = sel_be;
            if (owner_q) m1_waitrequest = s_waitrequest;
            else         m0_waitrequest = s_waitrequest;
            if (!sel_rd && !sel_wr) begin
               state_d = StIdle;
            end else if (!s_waitrequest) begin
               if (sel_wr) begin
                  state_d   = StIdle;
                  rr_next_d = ~owner_q;
               end else begin
                  state_d = StRdwait;
                  cnt_d   = '0;
               end
            end
         end
         StRdwait: begin
            cnt_d = cnt_q + CW'(1);
            // real data wins over a coinciding timeout
            if (s_readdatavalid) begin
               rd_valid  = 1'b1;
               rd_data   = s_readdata;
               state_d   = StIdle;
               rr_next_d = ~owner_q;
            end else if (cnt_q == TMO_LAST) begin
               rd_valid      = 1'b1;
               rd_data       = ERR_WORD;
               timeout_pulse = 1'b1;
               state_d       = StIdle;
               rr_next_d     = ~owner_q;
            end
         end
         default: state_d = StIdle;
      endcase

      m0_readdatavalid = rd_valid & ~owner_q;
      m1_readdatavalid = rd_valid & owner_q;
      m0_readdata      = m0_readdatavalid ? rd_data : '0;
      m1_readdata      = m1_readdatavalid ? rd_data : '0;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= StIdle;
         owner_q   <= 1'b0;
         rr_next_q <= 1'b0;
         cnt_q     <= '0;
      end else begin
         state_q   <= state_d;
         owner_q   <= owner_d;
         rr_next_q <= rr_next_d;
         cnt_q     <= cnt_d;
      end
   end

endmodule

// File: tb/tb_wavelink_avmm_arbiter.sv
// Directed bench for wavelink_avmm_arbiter: per-cycle vector table plus burst and timeout sequences.
module tb_wavelink_avmm_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic [15:0] m0_address, m1_address, s_address;
   logic        m0_read, m0_write, m1_read, m1_write;
   logic [31:0] m0_writedata, m1_writedata, s_writedata;
   logic [3:0]  m0_byteenable, m1_byteenable, s_byteenable;
   logic        m0_waitrequest, m1_waitrequest;
   logic [31:0] m0_readdata, m1_readdata, s_readdata;
   logic        m0_readdatavalid, m1_readdatavalid;
   logic        s_read, s_write, s_waitrequest, s_readdatavalid;
   logic        owner, timeout_pulse;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   wavelink_avmm_arbiter #(
      .AW          (16),
      .DW          (32),
      .TIMEOUT_CYC (16),
      .ERR_DATA    (32'hDEADBEEF)
   ) dut (
      .clk              (clk),
      .reset            (reset),
      .m0_address       (m0_address),
      .m0_read          (m0_read),
      .m0_write         (m0_write),
      .m0_writedata     (m0_writedata),
      .m0_byteenable    (m0_byteenable),
      .m0_waitrequest   (m0_waitrequest),
      .m0_readdata      (m0_readdata),
      .m0_readdatavalid (m0_readdatavalid),
      .m1_address       (m1_address),
      .m1_read          (m1_read),
      .m1_write         (m1_write),
      .m1_writedata     (m1_writedata),
      .m1_byteenable    (m1_byteenable),
      .m1_waitrequest   (m1_waitrequest),
      .m1_readdata      (m1_readdata),
      .m1_readdatavalid (m1_readdatavalid),
      .s_address        (s_address),
      .s_read           (s_read),
      .s_write          (s_write),
      .s_writedata      (s_writedata),
      .s_byteenable     (s_byteenable),
      .s_waitrequest    (s_waitrequest),
      .s_readdata       (s_readdata),
      .s_readdatavalid  (s_readdatavalid),
      .owner            (owner),
      .timeout_pulse    (timeout_pulse)
   );

   typedef struct {
      string       name;
      logic        rst;
      logic        m0_rd, m0_wr;
      logic [15:0] m0_addr;
      logic [31:0] m0_wd;
      logic        m1_rd, m1_wr;
      logic [15:0] m1_addr;
      logic [31:0] m1_wd;
      logic        s_wait, s_rdv;
      logic [31:0] s_rdata;
      logic [1:0]  e_wait;   // {m1, m0}
      logic [1:0]  e_rdv;    // {m1, m0}
      logic [31:0] e_rdata;
      logic        e_s_rd, e_s_wr;
      logic [15:0] e_s_addr;
      logic [31:0] e_s_wd;
      logic [3:0]  e_s_be;
      logic        e_owner, e_tmo;
   } vec_t;

   vec_t vecs[28];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, req);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic apply_vec(input vec_t v);
      step();
      reset           = v.rst;
      m0_read         = v.m0_rd;
      m0_write        = v.m0_wr;
      m0_address      = v.m0_addr;
      m0_writedata    = v.m0_wd;
      m1_read         = v.m1_rd;
      m1_write        = v.m1_wr;
      m1_address      = v.m1_addr;
      m1_writedata    = v.m1_wd;
      s_waitrequest   = v.s_wait;
      s_readdatavalid = v.s_rdv;
      s_readdata      = v.s_rdata;
      #2;
      chk({v.name, ".wait"}, {m1_waitrequest, m0_waitrequest}, v.e_wait);
      chk({v.name, ".rdv"}, {m1_readdatavalid, m0_readdatavalid}, v.e_rdv);
      chk({v.name, ".m0_rdata"}, m0_readdata, v.e_rdv[0] ? v.e_rdata : 32'h0);
      chk({v.name, ".m1_rdata"}, m1_readdata, v.e_rdv[1] ? v.e_rdata : 32'h0);
      chk({v.name, ".s_cmd"}, {s_read, s_write}, {v.e_s_rd, v.e_s_wr});
      chk({v.name, ".s_addr"}, s_address, v.e_s_addr);
      chk({v.name, ".s_wdata"}, s_writedata, v.e_s_wd);
      chk({v.name, ".s_be"}, s_byteenable, v.e_s_be);
      chk({v.name, ".owner_tmo"}, {owner, timeout_pulse}, {v.e_owner, v.e_tmo});
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int sent0, sent1, got0, got1, grants;
      logic        pend, exp_own;
      logic [31:0] pend_data;
      logic [15:0] exp_addr;

      reset = 1'b1;
      m0_address = '0; m0_read = 1'b0; m0_write = 1'b0; m0_writedata = '0;
      m1_address = '0; m1_read = 1'b0; m1_write = 1'b0; m1_writedata = '0;
      m0_byteenable = 4'hF;
      m1_byteenable = 4'h3;
      s_waitrequest = 1'b0; s_readdata = '0; s_readdatavalid = 1'b0;

      //           name rst m0rd m0wr m0addr m0wd m1rd m1wr m1addr m1wd swait srdv srdata
      //           | ewait erdv erdata esrd eswr esaddr eswd esbe eown etmo
      vecs[0]  = '{"rst_a", 1'b1, 1'b0, 1'b0, 16'h0, 32'h0, 1'b0, 1'b0, 16'h0, 32'h0, 1'b0, 1'b0,
                   32'h0, 2'b11, 2'b00, 32'h0, 1'b0, 1'b0, 16'h0, 32'h0, 4'h0, 1'b0, 1'b0};
      vecs[1]  = vecs[0]; vecs[1].name = "rst_b";
      vecs[2]  = vecs[0]; vecs[2].name = "rst_c";
      vecs[3]  = vecs[0]; vecs[3].name = "idle";  vecs[3].rst = 1'b0;
      vecs[4]  = '{"w0_req", 1'b0, 1'b0, 1'b1, 16'h0010, 32'h3FF, 1'b0, 1'b0, 16'h0, 32'h0, 1'b0,
                   1'b0, 32'h0, 2'b11, 2'b00, 32'h0, 1'b0, 1'b0, 16'h0, 32'h0, 4'h0, 1'b0, 1'b0};
      vecs[5]  = '{"w0_grant", 1'b0, 1'b0, 1'b1, 16'h0010, 32'h3FF, 1'b0, 1'b0, 16'h0, 32'h0, 1'b0,
                   1'b0, 32'h0, 2'b10, 2'b00, 32'h0, 1'b0, 1'b1, 16'h0010, 32'h3FF, 4'hF, 1'b0,
                   1'b0};
      vecs[6]  = vecs[3]; vecs[6].name = "w0_done";
      vecs[7]  = '{"w1_req", 1'b0, 1'b1, 1'b0, 16'h0030, 32'h0, 1'b0, 1'b1, 16'h0020,
                   32'hA5A50001, 1'b1, 1'b0, 32'h0, 2'b11, 2'b00, 32'h0, 1'b0, 1'b0, 16'h0, 32'h0,
                   4'h0, 1'b0, 1'b0};
      for (int i = 8; i <= 12; i++) begin
         vecs[i] = '{"w1_stall", 1'b0, 1'b1, 1'b0, 16'h0030, 32'h0, 1'b0, 1'b1, 16'h0020,
                     32'hA5A50001, 1'b1, 1'b0, 32'h0, 2'b11, 2'b00, 32'h0, 1'b0, 1'b1, 16'h0020,
                     32'hA5A50001, 4'h3, 1'b1, 1'b0};
      end
      vecs[13] = vecs[8]; vecs[13].name = "w1_accept"; vecs[13].s_wait = 1'b0;
      vecs[13].e_wait = 2'b01;
      vecs[14] = '{"r0_arb", 1'b0, 1'b1, 1'b0, 16'h0030, 32'h0, 1'b0, 1'b0, 16'h0, 32'h0, 1'b0,
                   1'b0, 32'h0, 2'b11, 2'b00, 32'h0, 1'b0, 1'b0, 16'h0, 32'h0, 4'h0, 1'b1, 1'b0};
      vecs[15] = '{"r0_issue", 1'b0, 1'b1, 1'b0, 16'h0030, 32'h0, 1'b0, 1'b0, 16'h0, 32'h0, 1'b0,
                   1'b0, 32'h0, 2'b10, 2'b00, 32'h0, 1'b1, 1'b0, 16'h0030, 32'h0, 4'hF, 1'b0, 1'b0};
      vecs[16] = vecs[3]; vecs[16].name = "r0_rdwait";
      vecs[17] = vecs[3]; vecs[17].name = "r0_data"; vecs[17].s_rdv = 1'b1;
      vecs[17].s_rdata = 32'h12345678; vecs[17].e_rdv = 2'b01; vecs[17].e_rdata = 32'h12345678;
      vecs[18] = '{"r1_req", 1'b0, 1'b0, 1'b0, 16'h0, 32'h0, 1'b1, 1'b0, 16'h0040, 32'h0, 1'b0,
                   1'b0, 32'h0, 2'b11, 2'b00, 32'h0, 1'b0, 1'b0, 16'h0, 32'h0, 4'h0, 1'b0, 1'b0};
      vecs[19] = '{"r1_issue", 1'b0, 1'b0, 1'b0, 16'h0, 32'h0, 1'b1, 1'b0, 16'h0040, 32'h0, 1'b0,
                   1'b0, 32'h0, 2'b01, 2'b00, 32'h0, 1'b1, 1'b0, 16'h0040, 32'h0, 4'h3, 1'b1, 1'b0};
      vecs[20] = vecs[3]; vecs[20].name = "r1_rdwait"; vecs[20].e_owner = 1'b1;
      vecs[21] = vecs[20]; vecs[21].name = "r1_rst"; vecs[21].rst = 1'b1;
      vecs[22] = vecs[3]; vecs[22].name = "r1_late"; vecs[22].s_rdv = 1'b1;
      vecs[22].s_rdata = 32'h0000CAFE;
      vecs[23] = '{"rr_both", 1'b0, 1'b1, 1'b0, 16'h0030, 32'h0, 1'b1, 1'b0, 16'h0040, 32'h0, 1'b0,
                   1'b0, 32'h0, 2'b11, 2'b00, 32'h0, 1'b0, 1'b0, 16'h0, 32'h0, 4'h0, 1'b0, 1'b0};
      vecs[24] = '{"rr_grant", 1'b0, 1'b1, 1'b0, 16'h0030, 32'h0, 1'b1, 1'b0, 16'h0040, 32'h0, 1'b0,
                   1'b0, 32'h0, 2'b10, 2'b00, 32'h0, 1'b1, 1'b0, 16'h0030, 32'h0, 4'hF, 1'b0, 1'b0};
      vecs[25] = '{"rr_data", 1'b0, 1'b0, 1'b0, 16'h0, 32'h0, 1'b1, 1'b0, 16'h0040, 32'h0, 1'b0,
                   1'b1, 32'h00000BAD, 2'b11, 2'b01, 32'h00000BAD, 1'b0, 1'b0, 16'h0, 32'h0, 4'h0,
                   1'b0, 1'b0};
      vecs[26] = vecs[0]; vecs[26].name = "clr_rst";
      vecs[27] = vecs[3]; vecs[27].name = "clr_idle";

      for (int i = 0; i < 28; i++) apply_vec(vecs[i]);

      // Contention burst: both masters stream 8 reads; slave is zero-wait, data one cycle later
      sent0 = 0; sent1 = 0; got0 = 0; got1 = 0; grants = 0;
      pend = 1'b0; pend_data = '0;
      for (int cyc = 0; cyc < 200 && !(got0 == 8 && got1 == 8); cyc++) begin
         step();
         m0_read         = (sent0 < 8);
         m0_address      = 16'h0100 + 16'(sent0 * 4);
         m1_read         = (sent1 < 8);
         m1_address      = 16'h0200 + 16'(sent1 * 4);
         s_waitrequest   = 1'b0;
         s_readdatavalid = pend;
         s_readdata      = pend ? pend_data : 32'h0;
         pend            = 1'b0;
         #2;
         if (s_read) begin
            exp_own  = grants[0];
            exp_addr = exp_own ? 16'h0200 + 16'(sent1 * 4) : 16'h0100 + 16'(sent0 * 4);
            chk("burst.owner", owner, exp_own);
            chk("burst.addr", s_address, exp_addr);
            pend      = 1'b1;
            pend_data = 32'hB000_0000 | {16'h0, s_address};
            if (!m0_waitrequest) sent0++;
            if (!m1_waitrequest) sent1++;
            grants++;
         end
         if (m0_readdatavalid) begin
            chk("burst.m0_data", m0_readdata, 32'hB000_0100 + 32'(got0 * 4));
            got0++;
         end
         if (m1_readdatavalid) begin
            chk("burst.m1_data", m1_readdata, 32'hB000_0200 + 32'(got1 * 4));
            got1++;
         end
      end
      chk("burst.m0_count", 64'(got0), 64'd8);
      chk("burst.m1_count", 64'(got1), 64'd8);
      chk("burst.grants", 64'(grants), 64'd16);

      // m1 read to a dead slave: error response 16 cycles after accept
      step();
      m0_read = 1'b0; s_readdatavalid = 1'b0; s_readdata = '0;
      m1_read = 1'b1; m1_address = 16'h0050;
      #2;
      chk("tmo.idle_wait", m1_waitrequest, 1'b1);
      step();
      #2;
      chk("tmo.accept", {s_read, m1_waitrequest}, 2'b10);
      for (int k = 1; k <= 16; k++) begin
         step();
         m1_read = 1'b0;
         #2;
         if (k < 16) begin
            chk("tmo.wait", {m1_readdatavalid, timeout_pulse}, 2'b00);
         end else begin
            chk("tmo.fire", {m1_readdatavalid, timeout_pulse, m0_readdatavalid}, 3'b110);
            chk("tmo.data", m1_readdata, 32'hDEADBEEF);
         end
      end
      step();
      s_readdatavalid = 1'b1; s_readdata = 32'h5555_5555;
      #2;
      chk("tmo.late", {m0_readdatavalid, m1_readdatavalid, timeout_pulse}, 3'b000);
      chk("tmo.late_data", m1_readdata, 32'h0);

      // Valid coinciding with the timeout cycle: real data, no pulse
      step();
      s_readdatavalid = 1'b0; s_readdata = '0;
      m0_read = 1'b1; m0_address = 16'h0060;
      #2;
      step();
      #2;
      chk("tie.accept", {s_read, m0_waitrequest}, 2'b10);
      for (int k = 1; k <= 16; k++) begin
         step();
         m0_read         = 1'b0;
         s_readdatavalid = (k == 16);
         s_readdata      = (k == 16) ? 32'h600D_DA7A : 32'h0;
         #2;
         if (k == 16) begin
            chk("tie.flags", {m0_readdatavalid, timeout_pulse}, 2'b10);
            chk("tie.data", m0_readdata, 32'h600D_DA7A);
         end
      end
      step();
      s_readdatavalid = 1'b0; s_readdata = '0;
      #2;
      chk("tie.idle", {m0_readdatavalid, m0_waitrequest, timeout_pulse}, 3'b010);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
